// File: rtl/risc_loader.sv
// Program loader and run supervisor for the 5-bit-address RISC core: streams an image
// into core memory, optionally reads it back (LOADER_VERIFY_EN), then runs the core until halt or timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_LOAD   | accept host bytes, write them to memory, core held in reset
// S_VERIFY | read image back and compare checksums (LOADER_VERIFY_EN)
// S_RUN    | core released, counting cycles until halt or timeout
// S_DONE   | core held in reset, results held until go
module risc_loader #(
    parameter int          AWIDTH     = 5,
    parameter int          DWIDTH     = 8,
    parameter int          CWIDTH     = 16,
    parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DWIDTH-1:0] in_data_i,
    input  logic              go_i,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_wr_o,
    output logic              mem_rd_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              cpu_rst_o,
    input  logic              cpu_halt_i,
    output logic              done_o,
    output logic              timeout_o,
    output logic              err_o,
    output logic [CWIDTH-1:0] cycles_o
);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [1:0] {S_LOAD, S_VERIFY, S_RUN, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;
`endif

    localparam logic [AWIDTH-1:0] ADDR_LAST = '1;
    localparam logic [CWIDTH-1:0] CYC_MAX   = CWIDTH'(MAX_CYCLES);
    localparam logic [CWIDTH-1:0] CYC_ONE   = CWIDTH'(1);

    state_t            state_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] csum_q;
    logic [CWIDTH-1:0] cycles_q;
    logic              done_q;
    logic              timeout_q;

`ifdef LOADER_VERIFY_EN
    logic [DWIDTH-1:0] rd_csum_q;
    logic [DWIDTH-1:0] rd_csum_d;
    logic              err_q;

    assign rd_csum_d = rd_csum_q + mem_rdata_i;
    assign mem_rd_o  = (state_q == S_VERIFY);
    assign err_o     = err_q;
    assign mem_addr_o = (state_q == S_LOAD || state_q == S_VERIFY) ? addr_q : '0;
`else
    logic unused_rdata;

    assign unused_rdata = ^mem_rdata_i;
    assign mem_rd_o     = 1'b0;
    assign err_o        = 1'b0;
    assign mem_addr_o   = (state_q == S_LOAD) ? addr_q : '0;
`endif

    assign in_ready_o  = (state_q == S_LOAD);
    assign mem_wr_o    = in_ready_o & in_valid_i;
    assign mem_wdata_o = in_data_i;
    assign cpu_rst_o   = (state_q != S_RUN);
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign cycles_o    = cycles_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_LOAD;
            addr_q    <= '0;
            csum_q    <= '0;
            cycles_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef LOADER_VERIFY_EN
            rd_csum_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid_i) begin
                        // address wraps to 0 after the last byte, ready for readback
                        addr_q <= addr_q + 1'b1;
                        csum_q <= csum_q + in_data_i;
                        if (addr_q == ADDR_LAST) begin
`ifdef LOADER_VERIFY_EN
                            state_q   <= S_VERIFY;
                            rd_csum_q <= '0;
`else
                            state_q  <= S_RUN;
                            cycles_q <= CYC_ONE;
`endif
                        end
                    end
                end
`ifdef LOADER_VERIFY_EN
                S_VERIFY: begin
                    addr_q    <= addr_q + 1'b1;
                    rd_csum_q <= rd_csum_d;
                    if (addr_q == ADDR_LAST) begin
                        if (rd_csum_d == csum_q) begin
                            state_q  <= S_RUN;
                            cycles_q <= CYC_ONE;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                S_RUN: begin
                    // halt has priority over a coincident timeout
                    if (cpu_halt_i) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (cycles_q == CYC_MAX) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        cycles_q <= cycles_q + CYC_ONE;
                    end
                end
                S_DONE: begin
                    if (go_i) begin
                        state_q   <= S_LOAD;
                        addr_q    <= '0;
                        csum_q    <= '0;
                        cycles_q  <= '0;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
`ifdef LOADER_VERIFY_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_loader.sv
// Self-checking bench for risc_loader: memory model, per-cycle behavioural reference
// and directed load/run/timeout/reset scenarios (adapts to LOADER_VERIFY_EN).
`timescale 1ns/1ps
module tb_risc_loader;
    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int MAXC  = 100;
    localparam int DEPTH = 32;
`ifdef LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, go, cpu_halt;
    logic [DW-1:0] in_data;
    logic          in_ready, mem_wr, mem_rd, cpu_rst, done, timeout, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] cycles;

    always #5 clk = ~clk;

    risc_loader #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW), .MAX_CYCLES(MAXC)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .go_i(go), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wr_o(mem_wr), .mem_rd_o(mem_rd), .mem_rdata_i(mem_rdata), .cpu_rst_o(cpu_rst),
        .cpu_halt_i(cpu_halt), .done_o(done), .timeout_o(timeout), .err_o(err), .cycles_o(cycles)
    );

    // core program memory; corrupt forces address 5 to read back 0x03
    logic [DW-1:0] mem [DEPTH];
    logic          corrupt;
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = (corrupt && mem_addr == 5'd5) ? 8'h03 : mem[mem_addr];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // reference: progress counted in bytes loaded, bytes read back and run length
    bit m_valid = 0;
    int m_loaded, m_vcount, m_run_len, m_wsum, m_rsum;
    bit m_fin, m_to, m_err;
    int wr_cnt  = 0;
    int rel_cnt = 0;

    always @(negedge clk) begin
        bit loading, verifying, running;
        loading   = !m_fin && m_loaded < DEPTH;
        verifying = VERIFY && !m_fin && m_loaded == DEPTH && m_vcount < DEPTH;
        running   = !m_fin && m_loaded == DEPTH && !verifying;
        if (m_valid) begin
            chk("in_ready", 32'(in_ready), 32'(loading));
            chk("mem_wr", 32'(mem_wr), 32'(loading && in_valid));
            chk("mem_rd", 32'(mem_rd), 32'(verifying));
            chk("cpu_rst", 32'(cpu_rst), 32'(!running));
            chk("mem_addr", 32'(mem_addr), loading ? m_loaded : (verifying ? m_vcount : 0));
            if (loading && in_valid) chk("mem_wdata", 32'(mem_wdata), 32'(in_data));
            chk("done", 32'(done), 32'(m_fin));
            chk("timeout", 32'(timeout), 32'(m_to));
            chk("err", 32'(err), 32'(m_err));
            chk("cycles", 32'(cycles), m_run_len);
            if (mem_wr) wr_cnt++;
            if (!cpu_rst) rel_cnt++;
        end
        if (rst || (m_fin && go)) begin
            m_valid = 1; m_loaded = 0; m_vcount = 0; m_run_len = 0;
            m_wsum = 0; m_rsum = 0; m_fin = 0; m_to = 0; m_err = 0;
        end else if (loading) begin
            if (in_valid) begin
                m_wsum += int'(in_data);
                m_loaded++;
                if (m_loaded == DEPTH && !VERIFY) m_run_len = 1;
            end
        end else if (verifying) begin
            m_rsum += int'(mem_rdata);
            m_vcount++;
            if (m_vcount == DEPTH) begin
                if ((m_rsum % 256) == (m_wsum % 256)) m_run_len = 1;
                else begin m_fin = 1; m_err = 1; end
            end
        end else if (running) begin
            if (cpu_halt) m_fin = 1;
            else if (m_run_len == MAXC) begin m_fin = 1; m_to = 1; end
            else m_run_len++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load(input int n, input logic [7:0] base, input int step, input int gap_after);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(int'(base) + i * step);
            tick();
            if (i == gap_after) begin
                in_valid = 1'b0;
                repeat (3) tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_run(output int k);
        k = 0;
        while (cpu_rst && k < 200) begin tick(); k++; end
        chk("run_start", 32'(cpu_rst), 32'd0);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 400) begin tick(); k++; end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic pulse_go();
        go = 1'b1; tick(); go = 1'b0;
    endtask

    initial begin
        int k, w0, r0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; go = 1'b0; cpu_halt = 1'b0; corrupt = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_cycles", 32'(cycles), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);

        // continuous load 0x00..0x1F, halt on 40th run cycle
        w0 = wr_cnt;
        load(32, 8'h00, 1, -1);
        chk("load1_writes", 32'(wr_cnt - w0), 32'd32);
        chk("load1_mem0", 32'(mem[0]), 32'h00);
        chk("load1_mem31", 32'(mem[31]), 32'h1F);
        wait_run(k);
        chk("run_latency", 32'(k), VERIFY ? 32'd32 : 32'd0);
        repeat (39) tick();
        cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_cycles", 32'(cycles), 32'd40);
        chk("halt_timeout", 32'(timeout), 32'd0);
        chk("halt_cpu_rst", 32'(cpu_rst), 32'd1);

        pulse_go();
        chk("go_in_ready", 32'(in_ready), 32'd1);
        chk("go_done", 32'(done), 32'd0);
        chk("go_cycles", 32'(cycles), 32'd0);

        // stalled load, then run to timeout
        w0 = wr_cnt;
        load(32, 8'h80, 1, 10);
        chk("gap_writes", 32'(wr_cnt - w0), 32'd32);
        chk("gap_mem10", 32'(mem[10]), 32'h8A);
        chk("gap_mem11", 32'(mem[11]), 32'h8B);
        wait_done();
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_cycles", 32'(cycles), 32'd100);
        chk("to_err", 32'(err), 32'd0);

        // halt coinciding with the timeout cycle
        pulse_go();
        load(32, 8'h20, 1, -1);
        wait_run(k);
        repeat (99) tick();
        cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
        chk("tie_done", 32'(done), 32'd1);
        chk("tie_timeout", 32'(timeout), 32'd0);
        chk("tie_cycles", 32'(cycles), 32'd100);

        // reset mid-load, full reload, reset mid-run
        pulse_go();
        load(20, 8'h40, 1, -1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rl_in_ready", 32'(in_ready), 32'd1);
        chk("rl_addr", 32'(mem_addr), 32'd0);
        w0 = wr_cnt;
        load(32, 8'h60, 1, -1);
        chk("rl_writes", 32'(wr_cnt - w0), 32'd32);
        chk("rl_mem0", 32'(mem[0]), 32'h60);
        chk("rl_mem19", 32'(mem[19]), 32'h73);
        wait_run(k);
        repeat (10) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rr_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rr_cycles", 32'(cycles), 32'd0);
        chk("rr_done", 32'(done), 32'd0);

`ifdef LOADER_VERIFY_EN
        // corrupted readback must never release the core
        corrupt = 1'b1;
        r0 = rel_cnt;
        load(32, 8'h01, 0, -1);
        wait_done();
        chk("vf_err", 32'(err), 32'd1);
        chk("vf_released", 32'(rel_cnt - r0), 32'd0);
        corrupt = 1'b0;
`else
        r0 = rel_cnt;
`endif
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
